// File: rtl/lc3b_types.sv
// Shared LC-3b types: word/mask widths plus the memory port arbiter's state,
// port and request-record definitions.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_A,
        GRANT_B
    } arb_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } arb_port_t;

    typedef struct packed {
        logic          read;
        logic          write;
        lc3b_mem_wmask wmask;
        lc3b_word      address;
        lc3b_word      wdata;
    } mem_req_t;

    // A port raising both strobes is performing a write; its read is dropped.
    function automatic mem_req_t make_req(
        input logic          read,
        input logic          write,
        input lc3b_mem_wmask wmask,
        input lc3b_word      address,
        input lc3b_word      wdata
    );
        mem_req_t r;
        r.read    = read & ~write;
        r.write   = write;
        r.wmask   = wmask;
        r.address = address;
        r.wdata   = wdata;
        return r;
    endfunction

endpackage

// File: rtl/mem_req_latch.sv
// Load-enabled holding register for the granted request, so the downstream
// port sees stable op/mask/address/data for the whole grant.
module mem_req_latch
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     load,
    input  mem_req_t req_d,
    output mem_req_t req_q
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q <= '0;
        end else if (load) begin
            req_q <= req_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch A, data B) to one downstream memory port arbiter with
// round-robin resolution of simultaneous requests.
module mem_port_arbiter
    import lc3b_types::*;
(
    input  logic          clk,
    input  logic          reset_n,

    input  logic          read_a,
    input  logic          write_a,
    input  lc3b_mem_wmask wmask_a,
    input  lc3b_word      address_a,
    input  lc3b_word      wdata_a,
    output logic          resp_a,
    output lc3b_word      rdata_a,

    input  logic          read_b,
    input  logic          write_b,
    input  lc3b_mem_wmask wmask_b,
    input  lc3b_word      address_b,
    input  lc3b_word      wdata_b,
    output logic          resp_b,
    output lc3b_word      rdata_b,

    output logic          mem_read,
    output logic          mem_write,
    output lc3b_mem_wmask mem_wmask,
    output lc3b_word      mem_address,
    output lc3b_word      mem_wdata,
    input  logic          mem_resp,
    input  lc3b_word      mem_rdata
);

    arb_state_t state, next_state;
    arb_port_t  last_winner, next_winner;
    arb_port_t  sel;
    logic       req_a, req_b;
    logic       load;
    mem_req_t   req_d, req_q;

    assign req_a = read_a | write_a;
    assign req_b = read_b | write_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_winner <= PORT_A;
        end else begin
            state       <= next_state;
            last_winner <= next_winner;
        end
    end

    always_comb begin
        next_state  = state;
        next_winner = last_winner;
        sel         = PORT_A;
        load        = 1'b0;
        unique case (state)
            IDLE: begin
                // On contention the previous loser wins; solo grants leave the history alone.
                if (req_a && req_b) begin
                    if (last_winner == PORT_A) begin
                        sel = PORT_B;
                    end else begin
                        sel = PORT_A;
                    end
                    next_winner = sel;
                    load        = 1'b1;
                end else if (req_a) begin
                    sel  = PORT_A;
                    load = 1'b1;
                end else if (req_b) begin
                    sel  = PORT_B;
                    load = 1'b1;
                end
                if (load) begin
                    if (sel == PORT_A) begin
                        next_state = GRANT_A;
                    end else begin
                        next_state = GRANT_B;
                    end
                end
            end
            GRANT_A, GRANT_B: begin
                if (mem_resp) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        if (sel == PORT_A) begin
            req_d = make_req(read_a, write_a, wmask_a, address_a, wdata_a);
        end else begin
            req_d = make_req(read_b, write_b, wmask_b, address_b, wdata_b);
        end
    end

    mem_req_latch u_req_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .req_d   (req_d),
        .req_q   (req_q)
    );

    // Strobes only while granted; the latched fields persist into IDLE harmlessly.
    assign mem_read    = req_q.read  & (state != IDLE);
    assign mem_write   = req_q.write & (state != IDLE);
    assign mem_wmask   = req_q.wmask;
    assign mem_address = req_q.address;
    assign mem_wdata   = req_q.wdata;

    assign resp_a  = mem_resp & (state == GRANT_A);
    assign resp_b  = mem_resp & (state == GRANT_B);
    assign rdata_a = mem_rdata;
    assign rdata_b = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus
// hand sequences for round-robin, mid-grant input changes and reset.
module tb_mem_port_arbiter;
    import lc3b_types::*;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          read_a, write_a, read_b, write_b;
    lc3b_mem_wmask wmask_a, wmask_b;
    lc3b_word      address_a, wdata_a, address_b, wdata_b;
    logic          resp_a, resp_b;
    lc3b_word      rdata_a, rdata_b;
    logic          mem_read, mem_write;
    lc3b_mem_wmask mem_wmask;
    lc3b_word      mem_address, mem_wdata;
    logic          mem_resp;
    lc3b_word      mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .read_a      (read_a),
        .write_a     (write_a),
        .wmask_a     (wmask_a),
        .address_a   (address_a),
        .wdata_a     (wdata_a),
        .resp_a      (resp_a),
        .rdata_a     (rdata_a),
        .read_b      (read_b),
        .write_b     (write_b),
        .wmask_b     (wmask_b),
        .address_b   (address_b),
        .wdata_b     (wdata_b),
        .resp_b      (resp_b),
        .rdata_b     (rdata_b),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wmask   (mem_wmask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata)
    );

    typedef struct packed {
        logic          rst_n;
        logic          rd_a;
        logic          wr_a;
        lc3b_word      addr_a;
        logic          rd_b;
        logic          wr_b;
        lc3b_mem_wmask mask_b;
        lc3b_word      addr_b;
        lc3b_word      wd_b;
        logic          mresp;
        lc3b_word      mrdata;
        logic          e_rd;
        logic          e_wr;
        lc3b_mem_wmask e_mask;
        lc3b_word      e_addr;
        lc3b_word      e_wd;
        logic          e_ra;
        logic          e_rb;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and land 2 time units after the edge, where inputs change.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        read_a = 0; write_a = 0; wmask_a = 0; address_a = 0; wdata_a = 0;
        read_b = 0; write_b = 0; wmask_b = 0; address_b = 0; wdata_b = 0;
        mem_resp = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        tick();
        reset_n = 1;
    endtask

    initial begin
        int order [4];
        int gap;
        int n;
        int gap_bad;

        //         rst rdA wrA addrA    rdB wrB mB addrB    wdB      rsp rdata     eRd eWr eM eAddr    eWd      eRA eRB
        vec[0]  = '{1, 1, 0, 16'h3000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0};
        vec[1]  = '{1, 1, 0, 16'h3000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h3000, 16'h0000, 0, 0};
        vec[2]  = '{1, 1, 0, 16'h3000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h3000, 16'h0000, 0, 0};
        vec[3]  = '{1, 1, 0, 16'h3000, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h1234, 1, 0, 0, 16'h3000, 16'h0000, 1, 0};
        vec[4]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h3000, 16'h0000, 0, 0};
        vec[5]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h3000, 16'h0000, 0, 0};
        vec[6]  = '{1, 1, 0, 16'h0010, 0, 1, 3, 16'h0020, 16'hBEEF, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0};
        vec[7]  = '{1, 1, 0, 16'h0010, 0, 1, 3, 16'h0020, 16'hBEEF, 1, 16'h0000, 0, 1, 3, 16'h0020, 16'hBEEF, 0, 1};
        vec[8]  = '{1, 1, 0, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 3, 16'h0020, 16'hBEEF, 0, 0};
        vec[9]  = '{1, 1, 0, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h5555, 1, 0, 0, 16'h0010, 16'h0000, 1, 0};
        vec[10] = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 0, 0};
        vec[11] = '{1, 0, 0, 16'h0000, 1, 1, 1, 16'h0050, 16'h00FF, 0, 16'h0000, 0, 0, 0, 16'h0010, 16'h0000, 0, 0};
        vec[12] = '{1, 0, 0, 16'h0000, 1, 1, 1, 16'h0050, 16'h00FF, 1, 16'hA5A5, 0, 1, 1, 16'h0050, 16'h00FF, 0, 1};
        vec[13] = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 1, 16'h0050, 16'h00FF, 0, 0};
        vec[14] = '{1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0050, 16'h00FF, 0, 0};

        reset_n = 0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1;
        #1;
        chk("reset mem_read",    mem_read,    0);
        chk("reset mem_write",   mem_write,   0);
        chk("reset mem_address", mem_address, 0);
        chk("reset mem_wdata",   mem_wdata,   0);
        chk("reset mem_wmask",   mem_wmask,   0);
        chk("reset resp_a",      resp_a,      0);
        chk("reset resp_b",      resp_b,      0);

        for (int i = 0; i < NVEC; i++) begin
            reset_n   = vec[i].rst_n;
            read_a    = vec[i].rd_a;
            write_a   = vec[i].wr_a;
            address_a = vec[i].addr_a;
            read_b    = vec[i].rd_b;
            write_b   = vec[i].wr_b;
            wmask_b   = vec[i].mask_b;
            address_b = vec[i].addr_b;
            wdata_b   = vec[i].wd_b;
            mem_resp  = vec[i].mresp;
            mem_rdata = vec[i].mrdata;
            #1;
            chk($sformatf("v%0d mem_read", i),    mem_read,    vec[i].e_rd);
            chk($sformatf("v%0d mem_write", i),   mem_write,   vec[i].e_wr);
            chk($sformatf("v%0d mem_wmask", i),   mem_wmask,   vec[i].e_mask);
            chk($sformatf("v%0d mem_address", i), mem_address, vec[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i),   mem_wdata,   vec[i].e_wd);
            chk($sformatf("v%0d resp_a", i),      resp_a,      vec[i].e_ra);
            chk($sformatf("v%0d resp_b", i),      resp_b,      vec[i].e_rb);
            chk($sformatf("v%0d rdata_a", i),     rdata_a,     vec[i].mrdata);
            chk($sformatf("v%0d rdata_b", i),     rdata_b,     vec[i].mrdata);
            tick();
        end
        reset_n = 1;

        // Continuous contention: expect B, A, B, A with one idle cycle before each grant.
        do_reset();
        read_a = 1; address_a = 16'h0100;
        read_b = 1; address_b = 16'h0200;
        n = 0; gap = 0; gap_bad = 0;
        for (int t = 0; t < 40 && n < 4; t++) begin
            #1;
            mem_resp = mem_read;
            #1;
            if (mem_read) begin
                order[n] = (mem_address == 16'h0200) ? 1 : 0;
                if (gap != 1) gap_bad++;
                if (order[n] == 1) chk("rr resp_b", {resp_b, resp_a}, 2'b10);
                else               chk("rr resp_a", {resp_b, resp_a}, 2'b01);
                n++;
                gap = 0;
            end else begin
                gap++;
            end
            tick();
            mem_resp = 0;
        end
        chk("rr transactions seen", n, 4);
        if (n == 4) begin
            chk("rr grant 0 is B", order[0], 1);
            chk("rr grant 1 is A", order[1], 0);
            chk("rr grant 2 is B", order[2], 1);
            chk("rr grant 3 is A", order[3], 0);
        end
        chk("rr single idle gaps", gap_bad, 0);
        idle_inputs();
        tick();

        // B moves its address while granted; the latched address must not follow.
        read_b = 1; address_b = 16'h0040;
        tick();
        address_b = 16'h0042;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold mem_read",    mem_read,    1);
            chk("hold mem_address", mem_address, 16'h0040);
            tick();
        end
        mem_resp = 1;
        #1;
        chk("hold resp_b",          resp_b,      1);
        chk("hold address at resp", mem_address, 16'h0040);
        tick();
        idle_inputs();
        tick();

        // Reset during GRANT_A coincident with mem_resp; nothing may follow.
        read_a = 1; address_a = 16'h0700;
        tick();
        #1;
        chk("rst grant mem_read", mem_read, 1);
        reset_n  = 0;
        mem_resp = 1;
        tick();
        reset_n = 1;
        read_a  = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post-rst mem_read",  mem_read,  0);
            chk("post-rst mem_write", mem_write, 0);
            chk("post-rst resp_a",    resp_a,    0);
            chk("post-rst resp_b",    resp_b,    0);
            tick();
        end
        chk("post-rst mem_address cleared", mem_address, 0);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the datapath's two word-wide memory ports onto one shared downstream memory port: port A (instruction fetch, read-only) and port B (data, read/write). It sits directly below the CPU datapath and above the single physical/cache memory interface, with the same request/response protocol on every side. It grants one port at a time and latches the granted request so the downstream side sees stable values. Contended grants alternate round-robin.

## Interface
Parameters:
- none; widths come from `lc3b_types` (`lc3b_word` = 16 bits).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `read_a`  in  1  port A read request; held until `resp_a`
- `write_a`  in  1  port A write request; the datapath ties it to 0, the arbiter still honours it
- `wmask_a`  in  2  port A byte mask
- `address_a`  in  16  port A address
- `wdata_a`  in  16  port A write data
- `resp_a`  out  1  port A completion
- `rdata_a`  out  16  port A read data
- `read_b`, `write_b`, `wmask_b`, `address_b`, `wdata_b`, `resp_b`, `rdata_b`  same as port A, for port B
- `mem_read`  out  1  downstream read strobe
- `mem_write`  out  1  downstream write strobe
- `mem_wmask`  out  2  latched mask
- `mem_address`  out  16  latched address
- `mem_wdata`  out  16  latched write data
- `mem_resp`  in  1  downstream completion
- `mem_rdata`  in  16  downstream read data

## Operation
- A port requests when `read_x | write_x`.
- If both `read_x` and `write_x` are set on one port, the request is a write and the read is ignored.
- FSM states: `IDLE`, `GRANT_A`, `GRANT_B`.
- `IDLE`:
  - Only A requests: go to `GRANT_A`.
  - Only B requests: go to `GRANT_B`.
  - Both request: grant the port that lost the previous contention, then update the `last_winner` register.
  - Uncontended grants do not change `last_winner`.
- On the grant edge, latch the winner's op (read/write), `wmask`, `address` and `wdata` into request registers.
- `GRANT_x`:
  - `mem_read`/`mem_write` are driven from the latched op.
  - Hold the state until `mem_resp` is high, then return to `IDLE` on that edge.
  - Requester inputs are ignored while granted; changes do not affect the latched request.
- `resp_x = mem_resp & (state == GRANT_x)`. The non-granted port's `resp` is always 0.
- `rdata_a` and `rdata_b` both equal `mem_rdata` combinationally. Only the port whose `resp` is high may consume it.
- `mem_resp` seen in `IDLE` is ignored.

## Timing
- Reset values:
  - state `IDLE`; `last_winner` = A, so B wins the first contention.
  - Request registers all 0.
  - `mem_read`, `mem_write`, `resp_a`, `resp_b` = 0; `mem_address`, `mem_wdata`, `mem_wmask` = 0.
- Request seen in `IDLE` at cycle N: `mem_read`/`mem_write` high from cycle N+1.
- `mem_resp` high at cycle M: `resp_x` high in cycle M, same cycle, combinational. State is `IDLE` at M+1; the next grant is visible at M+2.
- Minimum request-to-`resp` latency is 1 cycle (`mem_resp` in N+1). There is exactly one idle cycle between back-to-back transactions.
- Strobes and latched fields stay stable for the whole grant; there are no glitches on `mem_read`/`mem_write`.
- Reset asserted mid-grant: on the next edge, return to `IDLE` with strobes low. Any later `mem_resp` is dropped and no `resp_x` fires.
- Reset has priority over every transition, including a `mem_resp` arriving in the same cycle.

## Structure
- Add `arb_state_t` (enum `IDLE`/`GRANT_A`/`GRANT_B`) and `arb_port_t` (enum `PORT_A`/`PORT_B`) to `lc3b_types`.
- One natural sub-module: `mem_req_latch`. It is a load-enabled register holding op, `wmask`, `address` and `wdata`, with synchronous active-low clear. The FSM, round-robin logic and response steering live in the top module.

## Test plan
- A-only read, `address_a`=0x3000, memory returns 0x1234 after 3 cycles -> `mem_read`=1 with `mem_address`=0x3000 for 3 cycles; `resp_a`=1 and `rdata_a`=0x1234 for one cycle; `resp_b` stays 0.
- Reset, then A reads 0x0010 and B writes 0xBEEF to 0x0020 (mask 2'b11) in the same cycle -> B granted first (`mem_write`, `mem_address`=0x0020, `mem_wdata`=0xBEEF); A granted after B's `resp`.
- Continuous contention for 4 transactions -> grant order B, A, B, A, with exactly one `IDLE` cycle between each.
- B changes `address_b` from 0x0040 to 0x0042 mid-grant -> `mem_address` stays 0x0040 until `resp_b`.
- `reset_n` low during `GRANT_A` with `mem_resp` high in the same cycle -> next cycle is `IDLE`, strobes are 0 and `resp_a` never pulses after reset.
- B asserts `read_b` and `write_b` together with `wdata_b`=0x00FF -> `mem_write`=1, `mem_read`=0.
